// File: rtl/bus_master_if_pkg.sv
// Shared encodings for the CPU bus master: FSM states, strobe polarities and slave indices.
// No logic and no latency; constants only.
package bus_master_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_STALL  = 2'd3
    } state_t;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int IDX_W_DEF = 3;
    localparam int IDX_SPM   = 1;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Access-wait counter: clr wins over inc; count updates one edge after the request.
// expired is combinational from count; the caller gates inc to saturate.
module bus_timeout_cnt #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    output logic [TO_W-1:0] count,
    output logic            expired
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // A limit of zero means the wait never expires.
    assign expired = (TIMEOUT != 0) && (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_master_if.sv
// CPU bus master: zero-wait scratchpad path, request/grant/strobe/ready path to the shared bus.
// busy holds the CPU until the bus reports ready or the wait counter expires.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int BE_W    = DATA_W / 8,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int SPM_IDX = IDX_SPM,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    input  logic              as_,
    input  logic              rw,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [BE_W-1:0]   spm_be,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [BE_W-1:0]   bus_be,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] rd_buf;
    logic              err_buf;
    logic [TO_W-1:0]   count;
    logic              expired;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              start_bus;
    logic              granted;
    logic              done_ok;
    logic              done_to;
    logic              spm_hit;

    assign spm_hit     = (addr[ADDR_W-1 -: IDX_W] == IDX_W'(SPM_IDX));
    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_be      = be;
    assign spm_wr_data = wr_data;

    bus_timeout_cnt #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .count   (count),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_data    = '0;
        busy       = 1'b0;
        err        = 1'b0;
        spm_as_    = DISABLE_;
        start_bus  = 1'b0;
        granted    = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (as_ == ENABLE_ && !flush) begin
                    if (spm_hit) begin
                        if (!stall) begin
                            spm_as_ = ENABLE_;
                            if (rw == READ) rd_data = spm_rd_data;
                        end
                    end else begin
                        busy       = 1'b1;
                        start_bus  = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                busy = 1'b1;
                if (bus_grnt_ == ENABLE_) begin
                    granted    = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Ready takes priority over an expiry in the same cycle.
                if (bus_rdy_ == ENABLE_) begin
                    done_ok    = 1'b1;
                    if (bus_rw == READ) rd_data = bus_rd_data;
                    state_next = stall ? ST_STALL : ST_IDLE;
                end else if (expired) begin
                    done_to    = 1'b1;
                    err        = 1'b1;
                    rd_data    = '1;
                    state_next = stall ? ST_STALL : ST_IDLE;
                end else begin
                    busy    = 1'b1;
                    cnt_inc = (count != '1);
                end
            end
            ST_STALL: begin
                err = err_buf;
                if (rw == READ) rd_data = rd_buf;
                if (!stall) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req_    <= DISABLE_;
            bus_as_     <= DISABLE_;
            bus_rw      <= READ;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wr_data <= '0;
            rd_buf      <= '0;
            err_buf     <= 1'b0;
        end else begin
            if (start_bus) begin
                bus_req_    <= ENABLE_;
                bus_addr    <= addr;
                bus_rw      <= rw;
                bus_be      <= be;
                bus_wr_data <= wr_data;
            end
            if (granted) bus_as_ <= ENABLE_;
            // The strobe is a single-cycle pulse at the start of the access.
            if (state == ST_ACCESS) bus_as_ <= DISABLE_;
            if (done_ok || done_to) begin
                bus_req_    <= DISABLE_;
                bus_addr    <= '0;
                bus_be      <= '0;
                bus_wr_data <= '0;
                bus_rw      <= READ;
                err_buf     <= done_to;
            end
            if (done_ok && bus_rw == READ) rd_buf <= bus_rd_data;
            if (done_to) rd_buf <= '1;
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// Randomized bench for bus_master_if against a transaction-level model of wait, completion and timeout.
module tb_bus_master_if;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset, stall, flush, as_, rw;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wr_data, rd_data;
    logic        busy, err;
    logic [29:0] spm_addr;
    logic        spm_as_, spm_rw;
    logic [3:0]  spm_be;
    logic [31:0] spm_wr_data, spm_rd_data;
    logic        bus_req_, bus_grnt_;
    logic [29:0] bus_addr;
    logic        bus_as_, bus_rw;
    logic [3:0]  bus_be;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic        bus_rdy_;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_master_if #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .addr(addr), .as_(as_), .rw(rw), .be(be), .wr_data(wr_data),
        .rd_data(rd_data), .busy(busy), .err(err),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_be(spm_be),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_be(bus_be),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
        addr = '0; be = '0; wr_data = '0; spm_rd_data = '0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        step(); step();
        total++;
        if ({bus_req_, bus_as_, bus_rw} !== 3'b111) begin
            bad++; $display("FAIL reset_ctrl got=%b want=111", {bus_req_, bus_as_, bus_rw});
        end
        total++;
        if ({bus_addr, bus_be, bus_wr_data} !== 66'd0) begin
            bad++; $display("FAIL reset_bus got=%h want=0", {bus_addr, bus_be, bus_wr_data});
        end
        total++;
        if ({busy, err, spm_as_, rd_data} !== {3'b001, 32'h0}) begin
            bad++; $display("FAIL reset_out got=%b/%b/%b/%h want=0/0/1/0", busy, err, spm_as_, rd_data);
        end
        reset = 1'b0;
        step();
    endtask

    // Scratchpad access from IDLE; with stall the strobe must stay off.
    task automatic spm_access(input logic [29:0] a, input logic r_w, input logic [31:0] sd,
                              input logic [31:0] wd, input logic stl);
        logic [31:0] exp_rd;
        logic [29:0] aa;
        aa = a;
        aa[29:27] = 3'd1;
        exp_rd = (r_w && !stl) ? sd : 32'h0;
        addr = aa; rw = r_w; be = 4'hF; wr_data = wd; spm_rd_data = sd;
        as_ = 1'b0; flush = 1'b0; stall = stl;
        #1;
        total++;
        if ({spm_as_, busy, rd_data} !== {stl, 1'b0, exp_rd}) begin
            bad++; $display("FAIL spm_access got=%b/%b/%h want=%b/0/%h", spm_as_, busy, rd_data, stl, exp_rd);
        end
        total++;
        if ({spm_addr, spm_rw, spm_wr_data} !== {aa, r_w, wd}) begin
            bad++; $display("FAIL spm_copy got=%h/%b/%h want=%h/%b/%h", spm_addr, spm_rw, spm_wr_data, aa, r_w, wd);
        end
        step();
        as_ = 1'b1; stall = 1'b0;
    endtask

    task automatic test_spm();
        spm_access(30'h0800_0010, 1'b1, 32'hCAFE_0001, 32'h0, 1'b0);
        spm_access(30'h0800_0020, 1'b0, 32'h1111_2222, 32'h3333_4444, 1'b0);
        spm_access(30'h0800_0010, 1'b1, 32'hCAFE_0002, 32'h0, 1'b1);
    endtask

    // g = REQ cycles before grant, r = ACCESS cycle in which ready arrives (>TIMEOUT: never).
    task automatic run_bus(input logic [29:0] a, input logic r_w, input logic [3:0] b,
                           input logic [31:0] wd, input logic [31:0] rdd,
                           input int g, input int r, input logic stl, input int hold);
        int          term;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] stall_rd;
        term     = (r <= TIMEOUT) ? r : TIMEOUT;
        exp_err  = (r > TIMEOUT);
        exp_rd   = exp_err ? 32'hFFFF_FFFF : (r_w ? rdd : 32'h0);
        stall_rd = r_w ? exp_rd : 32'h0;

        addr = a; rw = r_w; be = b; wr_data = wd; as_ = 1'b0; flush = 1'b0; stall = 1'b0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = rdd;
        #1;
        total++;
        if ({busy, spm_as_, bus_req_} !== 3'b111) begin
            bad++; $display("FAIL bus_idle got=%b want=111", {busy, spm_as_, bus_req_});
        end
        step();
        for (int i = 0; i <= g; i++) begin
            bus_grnt_ = (i == g) ? 1'b0 : 1'b1;
            bus_rdy_  = 1'b0;
            stall     = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
            #1;
            total++;
            if ({busy, bus_req_, bus_as_} !== 3'b101) begin
                bad++; $display("FAIL bus_req cyc=%0d got=%b want=101", i, {busy, bus_req_, bus_as_});
            end
            total++;
            if ({bus_addr, bus_rw, bus_be, bus_wr_data} !== {a, r_w, b, wd}) begin
                bad++; $display("FAIL bus_latch got=%h/%b/%h/%h want=%h/%b/%h/%h",
                                bus_addr, bus_rw, bus_be, bus_wr_data, a, r_w, b, wd);
            end
            step();
        end
        for (int k = 1; k <= term; k++) begin
            bus_grnt_ = 1'b0;
            bus_rdy_  = (k == r) ? 1'b0 : 1'b1;
            stall     = (k == term) ? stl : 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
            #1;
            total++;
            if ({bus_as_, bus_req_} !== {(k == 1) ? 1'b0 : 1'b1, 1'b0}) begin
                bad++; $display("FAIL bus_strobe cyc=%0d got=%b want=%b0", k, {bus_as_, bus_req_}, (k != 1));
            end
            total++;
            if (k < term) begin
                if ({busy, err, rd_data} !== {2'b10, 32'h0}) begin
                    bad++; $display("FAIL access_wait cyc=%0d got=%b/%b/%h want=1/0/0", k, busy, err, rd_data);
                end
            end else begin
                if ({busy, err, rd_data} !== {1'b0, exp_err, exp_rd}) begin
                    bad++; $display("FAIL access_end cyc=%0d got=%b/%b/%h want=0/%b/%h",
                                    k, busy, err, rd_data, exp_err, exp_rd);
                end
            end
            step();
        end
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; flush = 1'b0;
        if (stl) begin
            for (int h = 0; h <= hold; h++) begin
                stall = (h == hold) ? 1'b0 : 1'b1;
                #1;
                total++;
                if ({busy, err, rd_data} !== {1'b0, exp_err, stall_rd}) begin
                    bad++; $display("FAIL stall_hold cyc=%0d got=%b/%b/%h want=0/%b/%h",
                                    h, busy, err, rd_data, exp_err, stall_rd);
                end
                step();
            end
        end
        as_ = 1'b1;
        #1;
        total++;
        if ({bus_req_, bus_as_, bus_rw, bus_addr, bus_be, bus_wr_data} !== {3'b111, 66'd0}) begin
            bad++; $display("FAIL bus_release got=%b%b%b/%h/%h/%h want=111/0/0/0",
                            bus_req_, bus_as_, bus_rw, bus_addr, bus_be, bus_wr_data);
        end
        total++;
        if ({busy, err, rd_data} !== {2'b00, 32'h0}) begin
            bad++; $display("FAIL after_idle got=%b/%b/%h want=0/0/0", busy, err, rd_data);
        end
    endtask

    task automatic test_bus_write();
        run_bus(30'h1000_0004, 1'b0, 4'b0011, 32'h1234_5678, 32'hDEAD_BEEF, 2, 3, 1'b0, 0);
        spm_access(30'h0, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b0);
    endtask

    task automatic test_bus_read_stall();
        run_bus(30'h1800_0040, 1'b1, 4'hF, 32'h0, 32'hA5A5_5A5A, 1, 2, 1'b1, 3);
        spm_access(30'h0, 1'b1, 32'h0000_ABCD, 32'h0, 1'b0);
    endtask

    task automatic test_timeout();
        run_bus(30'h2000_0008, 1'b1, 4'hF, 32'h0, 32'h7777_7777, 0, 99, 1'b0, 0);
        run_bus(30'h2000_000C, 1'b1, 4'hF, 32'h0, 32'h7777_7777, 1, 99, 1'b1, 2);
        run_bus(30'h2800_0000, 1'b1, 4'hF, 32'h0, 32'h5555_AAAA, 0, TIMEOUT, 1'b0, 0);
        spm_access(30'h0, 1'b1, 32'h1357_9BDF, 32'h0, 1'b0);
    endtask

    task automatic test_reset_in_access();
        addr = 30'h1000_0100; rw = 1'b1; be = 4'hF; as_ = 1'b0; flush = 1'b0; stall = 1'b0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        step();
        bus_grnt_ = 1'b0;
        step();
        bus_grnt_ = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0; as_ = 1'b1;
        #1;
        total++;
        if ({bus_req_, bus_as_, err, busy} !== 4'b1100) begin
            bad++; $display("FAIL reset_access got=%b want=1100", {bus_req_, bus_as_, err, busy});
        end
        spm_access(30'h0, 1'b1, 32'h2468_ACE0, 32'h0, 1'b0);
    endtask

    task automatic test_flush_idle();
        addr = 30'h0800_0010; rw = 1'b1; as_ = 1'b0; flush = 1'b1; stall = 1'b0;
        spm_rd_data = 32'hFACE_FACE;
        #1;
        total++;
        if ({spm_as_, busy, rd_data} !== {2'b10, 32'h0}) begin
            bad++; $display("FAIL flush_spm got=%b/%b/%h want=1/0/0", spm_as_, busy, rd_data);
        end
        step();
        addr = 30'h3000_0000;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL flush_busy got=%b want=0", busy);
        end
        step();
        total++;
        if (bus_req_ !== 1'b1) begin
            bad++; $display("FAIL flush_req got=%b want=1", bus_req_);
        end
        flush = 1'b0; as_ = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [29:0] a;
        int          idx;
        for (int n = 0; n < 16; n++) begin
            a   = 30'($urandom);
            idx = $urandom_range(0, 6);
            if (idx >= 1) idx++;
            a[29:27] = 3'(idx);
            run_bus(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(1, 6), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 3));
            spm_access(30'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom,
                       1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_spm();
        test_bus_write();
        test_bus_read_stall();
        test_timeout();
        test_reset_in_access();
        test_flush_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
